// File: rtl/dsdaccel_imgfetch_ctrl.sv
// Image ROM fetch sequencer: drives ROM word addresses and aligner controls.
// Optional perf counters (o_STALL_CNT/o_BEAT_CNT) under IMGFETCH_PERF_EN.
module dsdaccel_imgfetch_ctrl #(
  parameter int IAW    = 10,
  parameter int LW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic           i_CLK,
  input  logic           i_RST,
  input  logic           i_START,
  input  logic [IAW+3:0] i_BYTE_ADDR,
  input  logic [LW-1:0]  i_BEATS,
  input  logic           i_STALL,
  output logic           o_BUSY,
  output logic           o_DONE,
  output logic [IAW-1:0] o_ROM_ADDR,
  output logic           o_ROM_HOLD,
  output logic           o_OFFSET_WE,
  output logic [4:0]     o_OFFSET,
  output logic           o_VALID,
  output logic [LW-1:0]  o_BEAT_IDX
`ifdef IMGFETCH_PERF_EN
  ,
  output logic [15:0]    o_STALL_CNT,
  output logic [15:0]    o_BEAT_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [RD_LAT-1:0] TOP = 1 << (RD_LAT - 1);
  localparam logic LAT_ODD = (RD_LAT % 2) == 1;
  localparam logic [LW:0] REM_ONE = 1;

  state_t          state;
  state_t          state_nx;
  logic [IAW-1:0]  addr;
  logic [3:0]      boff;
  logic [LW:0]     rem;
  logic [RD_LAT-1:0] vp;
  logic [LW-1:0]   beat;
  logic            par;
  logic            done;

  logic start_ok;
  logic start_zero;
  logic issue;
  logic push;
  logic consume;
  logic drained;

  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    drained    = 1'b0;
    unique case (state)
      IDLE: begin
        start_ok   = i_START && (i_BEATS != '0);
        start_zero = i_START && (i_BEATS == '0);
        if (start_ok) state_nx = PRIME;
      end
      PRIME: begin
        issue = !i_STALL;
        if (issue) state_nx = STREAM;
      end
      STREAM: begin
        issue = !i_STALL;
        push  = issue;
        if (issue && rem == REM_ONE) state_nx = DRAIN;
      end
      DRAIN: begin
        drained = !i_STALL && ((vp & ~TOP) == '0);
        if (drained) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_BUSY      = (state != IDLE);
  assign o_DONE      = done;
  assign o_ROM_ADDR  = addr;
  assign o_ROM_HOLD  = o_BUSY && i_STALL;
  assign o_VALID     = vp[RD_LAT-1];
  assign o_BEAT_IDX  = o_VALID ? beat : '0;
  assign o_OFFSET_WE = (state == PRIME) && !i_STALL;
  // Slot the prime word lands in: parity advances RD_LAT times unstalled.
  assign o_OFFSET    = o_OFFSET_WE ? {par ^ LAT_ODD, boff} : '0;
  assign consume     = o_VALID && !i_STALL;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= IDLE;
      addr  <= '0;
      boff  <= '0;
      rem   <= '0;
      vp    <= '0;
      beat  <= '0;
      par   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      par   <= o_ROM_HOLD ? par : ~par;
      done  <= start_zero || drained;
      if (start_ok) begin
        addr <= i_BYTE_ADDR[IAW+3:4];
        boff <= i_BYTE_ADDR[3:0];
        rem  <= {1'b0, i_BEATS} + REM_ONE;
        beat <= '0;
      end
      if (issue) begin
        rem <= rem - REM_ONE;
        if (rem != REM_ONE) addr <= addr + 1'b1;
      end
      if (!i_STALL) vp <= (vp << 1) | RD_LAT'(push);
      if (consume) beat <= beat + 1'b1;
    end
  end

`ifdef IMGFETCH_PERF_EN
  logic [15:0] scnt;
  logic [15:0] bcnt;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      scnt <= '0;
      bcnt <= '0;
    end else if (state == IDLE && i_START) begin
      scnt <= '0;
      bcnt <= '0;
    end else begin
      if (o_ROM_HOLD && scnt != '1) scnt <= scnt + 1'b1;
      if (consume && bcnt != '1) bcnt <= bcnt + 1'b1;
    end
  end

  assign o_STALL_CNT = scnt;
  assign o_BEAT_CNT  = bcnt;
`endif

endmodule
